rate_divider_pulse_gen: RTL
===========================

Name: rate_divider_pulse_gen

Overview:
Programmable rate divider that produces the single-cycle Enable strobe consumed by the team's T-flip-flop up-counters. It is built on a loadable down-counter that reloads at terminal count, and sits between the board clock and any counter or display datapath. It offers four selectable rates, pause/resume, and a visible current count for debug.

Parameters:
CLK_HZ, 50_000_000, board clock frequency; sets the 1 Hz reload value (CLK_HZ-1).
WIDTH, 28, down-counter width; must satisfy 2^WIDTH > 4*CLK_HZ-1 (checked at elaboration).

Ports:
Clock  input  1  system clock, all state on rising edge.
Clear_b  input  1  reset, asynchronous, active-low.
Run  input  1  1 = count, 0 = pause (count held).
Speed  input  2  rate select: 00 full rate, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz.
Pulse  output  1  registered one-cycle strobe at the selected rate.
RateCount  output  WIDTH  current down-counter value.

Behaviour:
- Reload value R(Speed): 00 -> 0, 01 -> CLK_HZ-1, 10 -> 2*CLK_HZ-1, 11 -> 4*CLK_HZ-1; computed at WIDTH bits with no truncation.
- Reset (Clear_b=0, asynchronous): RateCount=0, Pulse=0, speed_q=00. All outputs registered.
- speed_q is Speed registered every cycle; change = (Speed != speed_q).
- Per rising edge, priority order:
  1. change=1 -> RateCount <= R(Speed), Pulse <= 0. This applies regardless of Run.
  2. Run=0 -> RateCount holds, Pulse <= 0.
  3. RateCount==0 -> RateCount <= R(speed_q), Pulse <= 1.
  4. Otherwise -> RateCount <= RateCount-1, Pulse <= 0.
- Period: with Run held high and Speed stable, Pulse is high exactly 1 of every R+1 cycles. For Speed=00, Pulse stays high continuously.
- The first pulse after a speed change comes R+1 cycles after the reload edge.
- Pause mid-count:
  - the count is frozen, and resumes from the same value when Run returns high;
  - no pulse is lost or duplicated.
- A speed change and terminal count on the same edge: the change wins, the count reloads, and no pulse is issued.
- Run falling on a terminal-count edge: no pulse is issued and the count stays at 0. The pulse fires on the first edge after Run returns high.
- Reset mid-count:
  - asynchronously clears the count and Pulse, and speed_q becomes 00;
  - on the first edge after release with Speed != 00, the change path reloads R(Speed) and no pulse is issued;
  - with Speed = 00 and Run = 1, pulses start on the first edge.
- The counter never underflows; decrement happens only when RateCount > 0.

Decomposition:
- Package rate_pkg holds:
  - the speed encodings as localparams (SPEED_FULL=2'b00, SPEED_1HZ=2'b01, SPEED_HALF=2'b10, SPEED_QUARTER=2'b11);
  - a function reload_value(speed, clk_hz) returning WIDTH bits.
- Sub-module load_down_counter (WIDTH parameter; ports Clock, Clear_b, Load, LoadVal, Dec, Q, Zero) holds the count register.
- The top module holds the speed_q register, the priority logic and the Pulse register.

Test Plan:
All scenarios use CLK_HZ=4 and WIDTH=8.
- Reset release; Speed=01, Run=1 held 20 cycles -> first edge reloads RateCount=3, then Pulse high on cycles 5, 9, 13, 17; RateCount sequence 3,2,1,0,3...
- Speed=11, Run=1 -> Pulse every 16 cycles, RateCount reloads to 15; Speed=00 -> Pulse high every cycle and RateCount stays 0.
- Speed=01 with RateCount=2, Run low 5 cycles -> RateCount holds 2 and Pulse stays 0; Run high -> Pulse exactly 3 edges later.
- Speed changes 01->10 on the edge where RateCount==0 -> no pulse, RateCount=7, next pulse 8 cycles later.
- Clear_b asserted asynchronously mid-cycle with RateCount=5 under Speed=11 -> RateCount=0 and Pulse=0 immediately, without waiting for an edge; after release, the first edge reloads 15 with no pulse.
- Run toggles low exactly on a terminal-count edge -> no pulse; Run high again -> pulse on the first edge.

Source files
------------

// File: rtl/rate_pkg.sv
// Shared speed encodings and reload-value helper for the rate divider.
package rate_pkg;

  localparam logic [1:0] SPEED_FULL    = 2'b00;
  localparam logic [1:0] SPEED_1HZ     = 2'b01;
  localparam logic [1:0] SPEED_HALF    = 2'b10;
  localparam logic [1:0] SPEED_QUARTER = 2'b11;

  // Wide enough for any practical clock; callers cast down to their counter width.
  localparam int unsigned RELOAD_W = 64;

  function automatic logic [RELOAD_W-1:0] reload_value(input logic [1:0] speed,
                                                      input int unsigned clk_hz);
    logic [RELOAD_W-1:0] hz;
    hz = RELOAD_W'(clk_hz);
    case (speed)
      SPEED_FULL: return '0;
      SPEED_1HZ:  return hz - RELOAD_W'(1);
      SPEED_HALF: return (hz << 1) - RELOAD_W'(1);
      default:    return (hz << 2) - RELOAD_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/rate_divider_pulse_gen_load_down_counter.sv
// Loadable down-counter with terminal-count flag; holds at zero when not reloaded.
module load_down_counter #(
  parameter int unsigned WIDTH = 28
) (
  input  logic             Clock,
  input  logic             Clear_b,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             Dec,
  output logic [WIDTH-1:0] Q,
  output logic             Zero
);

  assign Zero = (Q == '0);

  always_ff @(posedge Clock or negedge Clear_b) begin
    if (!Clear_b) begin
      Q <= '0;
    end else if (Load) begin
      Q <= LoadVal;
    end else if (Dec && !Zero) begin
      Q <= Q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/rate_divider_pulse_gen.sv
// Programmable rate divider: one-cycle Pulse strobe at one of four selectable rates.
module rate_divider_pulse_gen
  import rate_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned WIDTH  = 28
) (
  input  logic             Clock,
  input  logic             Clear_b,
  input  logic             Run,
  input  logic [1:0]       Speed,
  output logic             Pulse,
  output logic [WIDTH-1:0] RateCount
);

  localparam logic [RELOAD_W-1:0] MAX_RELOAD = reload_value(SPEED_QUARTER, CLK_HZ);

  // Slowest reload value must fit in the counter without truncation.
  if (WIDTH < RELOAD_W && (MAX_RELOAD >> WIDTH) != '0) begin : g_width_check
    $error("rate_divider_pulse_gen: WIDTH too small for 4*CLK_HZ-1");
  end

  logic [1:0]       speed_q;
  logic             change;
  logic             zero;
  logic             load;
  logic             dec;
  logic             pulse_d;
  logic [WIDTH-1:0] load_val;

  assign change = (Speed != speed_q);

  // Priority: speed change, pause, terminal count, decrement.
  always_comb begin
    load     = 1'b0;
    dec      = 1'b0;
    pulse_d  = 1'b0;
    load_val = '0;
    if (change) begin
      load     = 1'b1;
      load_val = WIDTH'(reload_value(Speed, CLK_HZ));
    end else if (!Run) begin
      load = 1'b0;
    end else if (zero) begin
      load     = 1'b1;
      load_val = WIDTH'(reload_value(speed_q, CLK_HZ));
      pulse_d  = 1'b1;
    end else begin
      dec = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Clear_b) begin
    if (!Clear_b) begin
      speed_q <= SPEED_FULL;
      Pulse   <= 1'b0;
    end else begin
      speed_q <= Speed;
      Pulse   <= pulse_d;
    end
  end

  load_down_counter #(.WIDTH(WIDTH)) u_counter (
    .Clock   (Clock),
    .Clear_b (Clear_b),
    .Load    (load),
    .LoadVal (load_val),
    .Dec     (dec),
    .Q       (RateCount),
    .Zero    (zero)
  );

endmodule
